arithmetic_left_shift_saturating_iterative: RTL
===============================================

// Module: arithmetic_left_shift_saturating_iterative
//
// PURPOSE
//   Signed multiply by a power of two, the inverse of the signed
//   divide-by-2**S arithmetic right shift.
//   - Computes res = a * 2**s, saturated to the N-bit signed range.
//   - Iterative datapath: one bit of shift per clock.
//   - valid/ready handshake on both the argument side and the result side.
//   - Sits in the arithmetic/pipelining exercise set as a multi-cycle
//     scaling unit ahead of fixed-point consumers.
//
// PARAMETERS
//   N   8                 operand/result width, signed two's complement, N >= 2
//   SW  $clog2(N) + 1     width of shift amount s; allows s >= N
//
// PORTS
//   clk      in   1   clock, all state updates on posedge
//   rst      in   1   synchronous, ACTIVE-LOW reset (asserted when rst == 0)
//   arg_vld  in   1   argument valid
//   arg_rdy  out  1   block can accept an argument (high only in IDLE)
//   a        in   N   signed operand, sampled on accept
//   s        in   SW  unsigned shift amount, sampled on accept
//   res_vld  out  1   result valid
//   res_rdy  in   1   downstream accepts result
//   res      out  N   signed saturated result
//   ovf      out  1   result was saturated (qualified by res_vld)
//
// BEHAVIOUR
//   Interface
//   - One clock domain.
//   - Reset is synchronous and active-low. At every posedge with rst == 0:
//     state = IDLE, res_vld = 0, res = 0, ovf = 0, shift counter = 0.
//     arg_rdy = 1 in the first cycle after reset.
//   - arg_rdy is a combinational decode of state == IDLE. It is never high
//     in SHIFT or DONE; there is no overlap of operations.
//   - Accept = arg_vld & arg_rdy at a posedge. On accept, capture:
//     val = a, cnt = s, sgn = a[N-1]; clear the sticky ovf.
//
//   FSM (3 states)
//   - IDLE -> SHIFT on accept with s != 0.
//   - IDLE -> DONE on accept with s == 0. No shift; res = a, ovf = 0.
//   - SHIFT, each cycle:
//     - if val[N-1] != val[N-2], set ovf (sticky);
//     - val <= val << 1, LSB filled with 0;
//     - cnt <= cnt - 1;
//     - when cnt == 1 at the edge, go to DONE.
//   - DONE: res_vld = 1.
//     - res = ovf ? (sgn ? 100..0 (min) : 011..1 (max)) : val.
//     - On res_vld & res_rdy at a posedge -> IDLE, res_vld drops next cycle.
//
//   Timing and datapath rules
//   - Latency is fixed at s+1 cycles from the accepting edge to res_vld
//     (s == 0 gives 1). There is no early exit on overflow.
//   - res and ovf are stable while res_vld = 1 and res_rdy = 0.
//   - Width rule: the result is the exact value when -2**(N-1) <= a*2**s
//     <= 2**(N-1)-1; otherwise it clamps to the signed boundary with the
//     sign of a.
//   - a == 0: res = 0, ovf = 0 for any s, including s >= N.
//   - a != 0 with s >= N: always saturates, ovf = 1.
//   - arg_vld while busy is ignored and not queued. The upstream must hold
//     it until arg_rdy.
//   - Reset mid-SHIFT or mid-DONE: the operation is abandoned, no res_vld
//     is emitted, and the block is in IDLE on the next cycle.
//
// TESTING  (N = 8, SW = 4; every result also checked vs a model
//          clamp(a * 2**s))
//   1. a=5, s=3, res_rdy=1
//      -> res=40 (0010_1000), ovf=0, res_vld exactly 4 cycles after accept.
//   2. a=-3 (1111_1101), s=5
//      -> res=-96 (1010_0000), ovf=0.
//      a=-128, s=0 -> res=-128, ovf=0, latency 1.
//   3. a=100, s=1 -> res=127, ovf=1.
//      a=-100, s=1 -> res=-128, ovf=1.
//      a=1, s=8 -> res=127, ovf=1.
//      a=0, s=15 -> res=0, ovf=0.
//   4. Backpressure: a=7, s=2, res_rdy=0 for 5 cycles after res_vld
//      -> res=28 held stable, arg_rdy=0, and a new arg_vld pulse is not
//      accepted. Release res_rdy -> IDLE, next argument accepted.
//   5. rst=0 for one cycle while in SHIFT (a=9, s=6)
//      -> IDLE next cycle, res_vld never asserts, arg_rdy=1.
//      The next op (a=2, s=2) gives res=8.
//   6. Random: 1000 ops, random a, s in 0..15, random res_rdy/arg_vld gaps
//      -> every result matches the model, exactly one result per accept.

Source files
------------

// File: rtl/arithmetic_left_shift_saturating_iterative.sv
// rtl/arithmetic_left_shift_saturating_iterative.sv - saturating a*2**s, one shift bit per clock
module arithmetic_left_shift_saturating_iterative #(
   parameter int N  = 8,
   parameter int SW = $clog2(N) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          arg_vld,
   output logic          arg_rdy,
   input  logic [N-1:0]  a,
   input  logic [SW-1:0] s,
   output logic          res_vld,
   input  logic          res_rdy,
   output logic [N-1:0]  res,
   output logic          ovf
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};

   logic [1:0]    state;
   logic [N-1:0]  val;
   logic [SW-1:0] cnt;
   logic          sgn;
   logic          ovf_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         val   <= '0;
         cnt   <= '0;
         sgn   <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (arg_vld) begin
                  val   <= a;
                  cnt   <= s;
                  sgn   <= a[N-1];
                  ovf_q <= 1'b0;
                  state <= (s == '0) ? DONE : SHIFT;
               end
            end
            SHIFT: begin
               // Losing a bit that differs from the new sign means the product left the range.
               if (val[N-1] != val[N-2])
                  ovf_q <= 1'b1;
               val <= {val[N-2:0], 1'b0};
               cnt <= cnt - 1'b1;
               if (cnt == SW'(1))
                  state <= DONE;
            end
            DONE: begin
               if (res_rdy)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign arg_rdy = (state == IDLE);
   assign res_vld = (state == DONE);
   assign res     = ovf_q ? (sgn ? SAT_MIN : SAT_MAX) : val;
   assign ovf     = ovf_q;

endmodule
